iter_divider: RTL and testbench
===============================

ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width (>=4, even).
REQ-002 SHALL have parameter: TAG_W, 5, width of pass-through tag (destination register number).
REQ-003 SHALL have port: aclk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port: areset  input  1  one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port: in_valid  input  1  request present.
REQ-006 SHALL have port: in_ready  output  1  block can accept request.
REQ-007 SHALL have port: op  input  2  00 DIV signed quotient, 01 MOD signed remainder, 10 DIVU, 11 MODU.
REQ-008 SHALL have port: dividend  input  WIDTH  numerator.
REQ-009 SHALL have port: divisor  input  WIDTH  denominator.
REQ-010 SHALL have port: tag_in  input  TAG_W  tag captured with request.
REQ-011 SHALL have port: flush  input  1  pipeline flush; abort any operation.
REQ-012 SHALL have port: out_valid  output  1  result present.
REQ-013 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-014 SHALL have port: result  output  WIDTH  quotient or remainder per op.
REQ-015 SHALL have port: tag_out  output  TAG_W  tag of the request producing result.
REQ-016 SHALL have port: div_by_zero  output  1  divisor was zero; valid with out_valid.

Function
REQ-017 SHALL implement FSM IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
REQ-018 SHALL drive in_ready high only in IDLE; accept when in_valid && in_ready && !flush, capturing op, operands, tag_in.
REQ-019 PREP (1 cycle) SHALL form unsigned magnitudes (signed ops: two's-complement absolute value; |MIN| = 2^(WIDTH-1) held unsigned) and record quotient sign (sign xor) and remainder sign (dividend sign).
REQ-020 CALC SHALL perform exactly WIDTH restoring radix-2 iterations, one per cycle, via a log2(WIDTH)+1-bit counter, using a WIDTH+1-bit partial remainder.
REQ-021 FIX (1 cycle) SHALL negate quotient/remainder per recorded signs and select the result by op.
REQ-022 out_valid SHALL be high only in DONE; result, tag_out, div_by_zero SHALL stay stable while out_valid && !out_ready.
REQ-023 Latency SHALL be exactly WIDTH+2 cycles from accepting edge to first out_valid cycle (full path).
REQ-024 DONE SHALL exit to IDLE on out_valid && out_ready; in_ready rises the following cycle (no same-cycle accept).
REQ-025 Divisor zero: quotient SHALL be all-ones, remainder SHALL equal dividend, div_by_zero=1; else div_by_zero=0.
REQ-026 Signed overflow (MIN / -1): quotient SHALL be MIN, remainder 0, div_by_zero=0.
REQ-027 Remainder sign SHALL follow dividend; quotient SHALL truncate toward zero.
REQ-028 flush SHALL force IDLE on the next edge from any state, discard the operation, and take priority over in_valid and out_ready; out_valid SHALL be low the cycle after flush.

Reset
REQ-029 areset SHALL asynchronously force IDLE; in_ready=1 after release, out_valid=0, result=0, tag_out=0, div_by_zero=0, counter=0.
REQ-030 areset mid-operation SHALL discard the operation; no out_valid until a new request completes.

Configuration
REQ-031 With DIV_EARLY_OUT_EN defined, PREP SHALL go directly to FIX when divisor==0 or |dividend| < |divisor| (quotient 0, remainder = dividend magnitude), latency 2 cycles; all other cases per REQ-023.
REQ-032 Without DIV_EARLY_OUT_EN, every operation SHALL take the full WIDTH+2 latency; results identical in both builds.

Verification
REQ-033 WIDTH=32: DIV 7 / -2 -> result 0xFFFFFFFD after 34 cycles; MOD 7 / -2 -> 0x00000001.
REQ-034 DIVU 0xFFFFFFFF / 0x10 -> 0x0FFFFFFF; MODU -> 0x0000000F; tag_in 5'd17 -> tag_out 5'd17.
REQ-035 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, div_by_zero=0; MOD -> 0x00000000.
REQ-036 DIVU 5 / 0 -> 0xFFFFFFFF, div_by_zero=1; MODU 5 / 0 -> 0x00000005; latency 2 with DIV_EARLY_OUT_EN, 34 without.
REQ-037 flush asserted 10 cycles into CALC -> no out_valid, in_ready=1 next cycle; next request DIVU 100 / 7 -> 14.
REQ-038 WIDTH=8: DIV 0x9C(-100) / 0x07 -> 0xF2(-14), 10-cycle latency; out_ready low 5 cycles -> result stable, in_ready low until handshake.

Source files
------------

// File: rtl/iter_divider.sv
// Iterative restoring radix-2 integer divider with valid/ready handshakes.
// Signed and unsigned DIV/MOD; quotient truncates toward zero and the
// remainder takes the sign of the dividend. A pass-through tag follows each
// request to its result.
// Optional build macro DIV_EARLY_OUT_EN: operations whose quotient is
// trivially zero (divisor zero or |dividend| < |divisor|) skip the iteration
// phase and complete in 2 cycles instead of WIDTH+2.
module iter_divider #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] tag_out,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int REM_W = WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t             state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [TAG_W-1:0]   tag_q;
  logic [REM_W-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   dmag_q;
  logic               neg_quo_q;
  logic               neg_rem_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   result_q;
  logic [TAG_W-1:0]   tag_out_q;
  logic               dbz_q;

  logic               a_neg_d;
  logic               b_neg_d;
  logic [WIDTH-1:0]   a_mag_d;
  logic [WIDTH-1:0]   b_mag_d;
  logic               early_out_d;
  logic [REM_W:0]     shift_rem_d;
  logic               rem_ge_d;
  logic [REM_W-1:0]   rem_next_d;
  logic [WIDTH-1:0]   quo_fix_d;
  logic [WIDTH-1:0]   rem_fix_d;
  logic [WIDTH-1:0]   quo_sel_d;
  logic [WIDTH-1:0]   rem_sel_d;
  logic [WIDTH-1:0]   result_d;

  // Datapath: operand magnitudes, one restoring step, and final sign fix-up.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path; a missing
    // assignment here would infer a latch.
    a_neg_d = ~op_q[1] & a_q[WIDTH-1];
    b_neg_d = ~op_q[1] & b_q[WIDTH-1];
    // -MIN wraps back to 2^(WIDTH-1), which is the correct unsigned magnitude.
    a_mag_d = a_neg_d ? -a_q : a_q;
    b_mag_d = b_neg_d ? -b_q : b_q;

`ifdef DIV_EARLY_OUT_EN
    early_out_d = (b_q == '0) || (a_mag_d < b_mag_d);
`else
    early_out_d = 1'b0;
`endif

    // Shift the next dividend bit into the partial remainder, then try to
    // subtract the divisor; keep the difference only when it does not borrow.
    shift_rem_d = {rem_q, quo_q[WIDTH-1]};
    rem_ge_d    = shift_rem_d >= {2'b00, dmag_q};
    rem_next_d  = rem_ge_d ? REM_W'(shift_rem_d - {2'b00, dmag_q})
                           : shift_rem_d[REM_W-1:0];

    quo_fix_d = neg_quo_q ? -quo_q : quo_q;
    rem_fix_d = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    // Division by zero has an architected result independent of the loop.
    if (dmag_q == '0) begin
      quo_sel_d = '1;
      rem_sel_d = a_q;
    end else begin
      quo_sel_d = quo_fix_d;
      rem_sel_d = rem_fix_d;
    end

    result_d = op_q[0] ? rem_sel_d : quo_sel_d;
  end

  // Control FSM plus all sequential datapath state and registered outputs.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dmag_q      <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      tag_out_q   <= '0;
      dbz_q       <= 1'b0;
    end else if (flush) begin
      // Flush outranks every other request, including a pending handshake.
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q       <= op;
            a_q        <= dividend;
            b_q        <= divisor;
            tag_q      <= tag_in;
            in_ready_q <= 1'b0;
            state_q    <= S_PREP;
          end
        end

        S_PREP: begin
          dmag_q    <= b_mag_d;
          neg_quo_q <= a_neg_d ^ b_neg_d;
          neg_rem_q <= a_neg_d;
          cnt_q     <= '0;
          if (early_out_d) begin
            quo_q   <= '0;
            rem_q   <= {1'b0, a_mag_d};
            state_q <= S_FIX;
          end else begin
            quo_q   <= a_mag_d;
            rem_q   <= '0;
            state_q <= S_CALC;
          end
        end

        S_CALC: begin
          rem_q <= rem_next_d;
          quo_q <= {quo_q[WIDTH-2:0], rem_ge_d};
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            cnt_q   <= '0;
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_FIX: begin
          result_q    <= result_d;
          tag_out_q   <= tag_q;
          dbz_q       <= (dmag_q == '0);
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign tag_out     = tag_out_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: a 32-bit instance driven through a
// scoreboard of directed and random requests, plus an 8-bit instance for the
// narrow-width and output back-pressure case.
module tb_iter_divider;

  localparam int W = 32;

  logic        aclk = 1'b0;
  logic        areset;
  always #5 aclk = ~aclk;

  // 32-bit instance signals
  logic        in_valid, in_ready, flush, out_valid, out_ready, div_by_zero;
  logic [1:0]  op;
  logic [31:0] dividend, divisor, result;
  logic [4:0]  tag_in, tag_out;

  // 8-bit instance signals
  logic        in_valid8, in_ready8, flush8, out_valid8, out_ready8, dbz8;
  logic [1:0]  op8;
  logic [7:0]  dividend8, divisor8, result8;
  logic [4:0]  tag_in8, tag_out8;

  iter_divider #(.WIDTH(32), .TAG_W(5)) dut (
    .aclk(aclk), .areset(areset),
    .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .dividend(dividend), .divisor(divisor), .tag_in(tag_in),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .tag_out(tag_out), .div_by_zero(div_by_zero)
  );

  iter_divider #(.WIDTH(8), .TAG_W(5)) dut8 (
    .aclk(aclk), .areset(areset),
    .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
    .dividend(dividend8), .divisor(divisor8), .tag_in(tag_in8),
    .flush(flush8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .tag_out(tag_out8), .div_by_zero(dbz8)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Reference behaviour written from the arithmetic definition, not the loop.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic dz);
    logic [31:0] q, m;
    int sa, sb_v;
    dz = (b == 32'd0);
    if (b == 32'd0) begin
      q = '1;
      m = a;
    end else if (!o[1]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        m = 32'd0;
      end else begin
        sa   = a;
        sb_v = b;
        q = 32'(sa / sb_v);
        m = 32'(sa % sb_v);
      end
    end else begin
      q = a / b;
      m = a % b;
    end
    r = o[0] ? m : q;
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    logic [31:0] ma, mb;
    ma = (!o[1] && a[31]) ? -a : a;
    mb = (!o[1] && b[31]) ? -b : b;
    if (b == 32'd0 || ma < mb) return 2;
`endif
    return W + 2;
  endfunction

  // One full request/response on the 32-bit instance; inputs change #1 after
  // the rising edge and outputs are sampled at the same point.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t);
    exp_t  e, got;
    int    n, lat;
    logic [31:0] r;
    logic  dz;
    string id;
    id = $sformatf("op%0d %h/%h", o, a, b);
    model(o, a, b, r, dz);
    e.res = r; e.tag = t; e.dz = dz; e.lat = exp_lat(o, a, b);
    sb.push_back(e);
    in_valid = 1'b1; op = o; dividend = a; divisor = b; tag_in = t;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge aclk); #1; n++; end
    check({id, " accept_in_time"}, 64'(n < 100), 64'd1);
    @(posedge aclk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge aclk); #1; lat++; end
    got = sb.pop_front();
    check({id, " out_valid"},   64'(out_valid),   64'd1);
    check({id, " latency"},     64'(lat),         64'(got.lat));
    check({id, " result"},      64'(result),      64'(got.res));
    check({id, " tag_out"},     64'(tag_out),     64'(got.tag));
    check({id, " div_by_zero"}, 64'(div_by_zero), 64'(got.dz));
    @(posedge aclk); #1;
    check({id, " out_valid_drop"}, 64'(out_valid), 64'd0);
    check({id, " in_ready_rise"},  64'(in_ready),  64'd1);
  endtask

  logic [1:0]  ro;
  logic [31:0] ra, rb;
  logic        bad;
  logic [7:0]  held8;
  int          n8;

  initial begin
    areset = 1'b1;
    in_valid = 1'b0; op = 2'b00; dividend = '0; divisor = '0; tag_in = '0;
    flush = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; op8 = 2'b00; dividend8 = '0; divisor8 = '0; tag_in8 = '0;
    flush8 = 1'b0; out_ready8 = 1'b0;

    // Reset state
    #12;
    check("rst in_ready",    64'(in_ready),    64'd1);
    check("rst out_valid",   64'(out_valid),   64'd0);
    check("rst result",      64'(result),      64'd0);
    check("rst tag_out",     64'(tag_out),     64'd0);
    check("rst div_by_zero", 64'(div_by_zero), 64'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    @(posedge aclk); #1;
    check("post_rst in_ready", 64'(in_ready), 64'd1);

    // Directed cases
    do_op(2'b00, 32'd7, 32'hFFFF_FFFE, 5'd3);
    do_op(2'b01, 32'd7, 32'hFFFF_FFFE, 5'd4);
    do_op(2'b10, 32'hFFFF_FFFF, 32'h10, 5'd17);
    do_op(2'b11, 32'hFFFF_FFFF, 32'h10, 5'd17);
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
    do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    do_op(2'b10, 32'd5, 32'd0, 5'd10);
    do_op(2'b11, 32'd5, 32'd0, 5'd11);
    do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd12);
    do_op(2'b01, 32'hFFFF_FFF9, 32'd2, 5'd13);
    do_op(2'b00, 32'd3, 32'd10, 5'd14);
    do_op(2'b01, 32'hFFFF_FFFD, 32'd10, 5'd15);
    do_op(2'b00, 32'hFFFF_FFFB, 32'd0, 5'd16);
    do_op(2'b01, 32'hFFFF_FFFB, 32'd0, 5'd18);

    // Flush ten cycles into the iteration phase
    in_valid = 1'b1; op = 2'b10; dividend = 32'd1000; divisor = 32'd3; tag_in = 5'd20;
    @(posedge aclk); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge aclk);
    #1 flush = 1'b1;
    @(posedge aclk); #1;
    flush = 1'b0;
    check("flush out_valid", 64'(out_valid), 64'd0);
    check("flush in_ready",  64'(in_ready),  64'd1);
    bad = 1'b0;
    repeat (40) begin @(posedge aclk); #1; if (out_valid) bad = 1'b1; end
    check("flush no_result", 64'(bad), 64'd0);
    do_op(2'b10, 32'd100, 32'd7, 5'd21);

    // Asynchronous reset in the middle of an operation
    in_valid = 1'b1; op = 2'b10; dividend = 32'd1000; divisor = 32'd3; tag_in = 5'd22;
    @(posedge aclk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge aclk);
    #3 areset = 1'b1;
    #1;
    check("mid_rst in_ready",  64'(in_ready),  64'd1);
    check("mid_rst out_valid", 64'(out_valid), 64'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    bad = 1'b0;
    repeat (40) begin @(posedge aclk); #1; if (out_valid) bad = 1'b1; end
    check("mid_rst no_result", 64'(bad), 64'd0);
    do_op(2'b00, 32'hFFFF_FF9C, 32'd7, 5'd23);

    // Random mix
    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case (i % 4)
        0: rb = 32'($urandom_range(1, 20));
        1: rb = $urandom;
        2: rb = -32'($urandom_range(1, 9));
        default: begin rb = $urandom; ra = 32'($urandom_range(0, 50)); end
      endcase
      do_op(ro, ra, rb, 5'(i));
    end

    // 8-bit instance: signed divide with held-off consumer
    in_valid8 = 1'b1; op8 = 2'b00; dividend8 = 8'h9C; divisor8 = 8'h07; tag_in8 = 5'd6;
    check("w8 in_ready", 64'(in_ready8), 64'd1);
    @(posedge aclk); #1;
    in_valid8 = 1'b0;
    n8 = 0;
    while (!out_valid8 && n8 < 50) begin @(posedge aclk); #1; n8++; end
    check("w8 latency", 64'(n8),       64'd10);
    check("w8 result",  64'(result8),  64'hF2);
    check("w8 tag_out", 64'(tag_out8), 64'd6);
    check("w8 dbz",     64'(dbz8),     64'd0);
    held8 = 8'hF2;
    bad = 1'b0;
    repeat (5) begin
      @(posedge aclk); #1;
      if (result8 !== held8 || !out_valid8 || in_ready8 || tag_out8 !== 5'd6) bad = 1'b1;
    end
    check("w8 stall_stable", 64'(bad), 64'd0);
    out_ready8 = 1'b1;
    @(posedge aclk); #1;
    out_ready8 = 1'b0;
    check("w8 out_valid_drop", 64'(out_valid8), 64'd0);
    check("w8 in_ready_rise",  64'(in_ready8),  64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
